rtc_bus_driver: RTL
===================

# rtc_bus_driver

Bus-cycle generator that sits directly downstream of the RTC main controller. It turns the controller's write and read requests into multiplexed address/data bus cycles on the external RTC chip. A request is a level on `actesc` or `actlec`, with the address on `dirreg` and the data on `datoreg`. The block reports completion on `esclisto` / `memorialisto`, and returns read data on `datolec`, which feeds the controller's `datomem` input.

## Interface
- `T_PULSE`, default 10: clock cycles that CS/WR/RD stay low per phase (100 ns at 100 MHz); must be ≥1.
- `T_GAP`, default 4: clock cycles with all strobes high between phases (≥1).
- `clk` in 1: system clock; one clock domain.
- `reset` in 1: reset, synchronous, active-high.
- `actesc` in 1: write request level from the controller.
- `actlec` in 1: read request level from the controller.
- `dirreg` in 8: RTC register address.
- `datoreg` in 8: write data.
- `ad_in` in 8: AD bus value sampled from the pad.
- `ad_out` out 8: value driven onto the AD bus.
- `ad_oe` out 1: AD output enable; the tristate buffer lives at top level.
- `cs_n` out 1: RTC chip select, active low.
- `wr_n` out 1: RTC write strobe, active low.
- `rd_n` out 1: RTC read strobe, active low.
- `a_d` out 1: phase select; 0 = address phase, 1 = data phase.
- `esclisto` out 1: write-complete level.
- `memorialisto` out 1: read-complete level.
- `datolec` out 8: last byte read from the RTC.

## Operation
- FSM states: IDLE, ADDR, GAP1, DATA, GAP2, DONE. A down-counter of width clog2(max(T_PULSE,T_GAP)+1) times each phase.
- All outputs are registers, updated on the same edge as the state register. No combinational path runs from inputs to outputs.
- Latched operation type `op` (write/read) is captured on leaving IDLE.

IDLE
- Outputs: `cs_n`=`wr_n`=`rd_n`=`a_d`=1, `ad_oe`=0.
- If `actesc`=1, go to ADDR with op=write. Else if `actlec`=1, go to ADDR with op=read.
- Write wins when both requests are high.
- `dirreg` and `datoreg` are latched into internal registers on this edge; later changes are ignored.

ADDR (T_PULSE cycles)
- Outputs: `a_d`=0, `cs_n`=0, `wr_n`=0, `ad_oe`=1, `ad_out`=latched address.
- This phase is identical for reads and writes.

GAP1 (T_GAP cycles)
- Strobes all high, `ad_oe`=0.

DATA (T_PULSE cycles), `a_d`=1, `cs_n`=0
- Write: `wr_n`=0, `ad_oe`=1, `ad_out`=latched data.
- Read: `rd_n`=0, `ad_oe`=0.
- On the edge that leaves DATA, `datolec` <= `ad_in`.

GAP2 (T_GAP cycles)
- Strobes all high, `ad_oe`=0.

DONE
- Asserts `esclisto` (write) or `memorialisto` (read), and holds it while the request that started the cycle stays high.
- When that request drops, return to IDLE and clear the flag on the same edge.
- A request that drops earlier, mid-cycle, does not abort the cycle; DONE then lasts exactly 1 cycle.

General rules
- `datolec` holds its value until the next read completes. Writes never modify it.
- `ad_oe` is never 1 while `rd_n`=0, so there is no bus contention.

Reset
- Values: `cs_n`=`wr_n`=`rd_n`=`a_d`=1, `ad_oe`=0, `ad_out`=0, `esclisto`=`memorialisto`=0, `datolec`=0, state=IDLE.
- A reset in any state releases the bus on the next edge. The aborted cycle produces no completion flag.

## Timing
- Let E0 be the first edge with a request high in IDLE.
- ADDR outputs are valid from E0 until E0+T_PULSE.
- GAP1 runs until E0+T_PULSE+T_GAP.
- DATA runs until E0+2·T_PULSE+T_GAP; read capture happens at that edge.
- GAP2 runs until E0+2·(T_PULSE+T_GAP).
- The completion flag rises at E0+2·(T_PULSE+T_GAP), which is E0+28 with defaults.
- The flag falls on the first edge where the request is sampled low.
- The earliest new transaction starts the edge after the return to IDLE. The flag and the bus strobes are never active together.

## Test plan
- Reset: hold `reset`=1 for 3 cycles with `actesc`=1 → all outputs at reset values, no strobe toggles.
- Write, defaults, `dirreg`=0x21, `datoreg`=0x59 → `ad_out`=0x21 with `wr_n`=0/`a_d`=0 for 10 cycles, gap 4, then 0x59 with `a_d`=1 for 10 cycles, gap 4. `esclisto`=1 at E0+28 and held until `actesc` drops.
- Read, `dirreg`=0x41, model drives `ad_in`=0x16 only while `rd_n`=0 → `datolec`=0x16 at E0+24. `memorialisto`=1 at E0+28. `ad_oe`=0 throughout DATA.
- Simultaneous `actesc`=`actlec`=1 → write cycle executed, only `esclisto` asserts. After both drop, `actlec` alone → read cycle.
- `actesc` dropped at E0+5 and `dirreg` changed mid-cycle → the cycle completes with the original address, `esclisto` high for exactly 1 cycle.
- `reset` at E0+15 (during DATA) → strobes high and `ad_oe`=0 at the next edge, no completion flag, `datolec` cleared. A new request afterwards completes normally.

Source files
------------

// File: rtl/rtc_bus_driver_if.sv
// rtc_bus_driver_if: controller requests (actesc/actlec/dirreg/datoreg), completion (esclisto/memorialisto/datolec) and RTC AD bus pins
interface rtc_bus_driver_if;
  logic       actesc;
  logic       actlec;
  logic [7:0] dirreg;
  logic [7:0] datoreg;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       wr_n;
  logic       rd_n;
  logic       a_d;
  logic       esclisto;
  logic       memorialisto;
  logic [7:0] datolec;
  modport master (
    output actesc, actlec, dirreg, datoreg, ad_in,
    input  ad_out, ad_oe, cs_n, wr_n, rd_n, a_d, esclisto, memorialisto, datolec
  );
  modport slave (
    input  actesc, actlec, dirreg, datoreg, ad_in,
    output ad_out, ad_oe, cs_n, wr_n, rd_n, a_d, esclisto, memorialisto, datolec
  );
endinterface

// File: rtl/rtc_bus_driver.sv
// rtc_bus_driver: turns write/read request levels into multiplexed RTC bus cycles; ports clk, reset, bus (slave: requests in, strobes/AD/flags/datolec out)
module rtc_bus_driver #(
  parameter int T_PULSE = 10,
  parameter int T_GAP   = 4
) (
  input logic            clk,
  input logic            reset,
  rtc_bus_driver_if.slave bus
);
  localparam int CW = $clog2((T_PULSE > T_GAP ? T_PULSE : T_GAP) + 1);
  typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2, DONE} state_t;
  state_t        state;
  logic          op;
  logic [7:0]    data;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      op               <= 1'b0;
      data             <= 8'h00;
      cnt              <= '0;
      bus.cs_n         <= 1'b1;
      bus.wr_n         <= 1'b1;
      bus.rd_n         <= 1'b1;
      bus.a_d          <= 1'b1;
      bus.ad_oe        <= 1'b0;
      bus.ad_out       <= 8'h00;
      bus.esclisto     <= 1'b0;
      bus.memorialisto <= 1'b0;
      bus.datolec      <= 8'h00;
    end else begin
      case (state)
        IDLE: if (bus.actesc || bus.actlec) begin
          state      <= ADDR;
          op         <= bus.actesc;
          data       <= bus.datoreg;
          cnt        <= CW'(T_PULSE - 1);
          bus.a_d    <= 1'b0;
          bus.cs_n   <= 1'b0;
          bus.wr_n   <= 1'b0;
          bus.ad_oe  <= 1'b1;
          bus.ad_out <= bus.dirreg;
        end
        ADDR: if (cnt == '0) begin
          state     <= GAP1;
          cnt       <= CW'(T_GAP - 1);
          bus.cs_n  <= 1'b1;
          bus.wr_n  <= 1'b1;
          bus.ad_oe <= 1'b0;
        end else cnt <= cnt - CW'(1);
        GAP1: if (cnt == '0) begin
          state      <= DATA;
          cnt        <= CW'(T_PULSE - 1);
          bus.a_d    <= 1'b1;
          bus.cs_n   <= 1'b0;
          bus.wr_n   <= ~op;
          bus.rd_n   <= op;
          bus.ad_oe  <= op;
          bus.ad_out <= data;
        end else cnt <= cnt - CW'(1);
        DATA: if (cnt == '0) begin
          state       <= GAP2;
          cnt         <= CW'(T_GAP - 1);
          bus.cs_n    <= 1'b1;
          bus.wr_n    <= 1'b1;
          bus.rd_n    <= 1'b1;
          bus.ad_oe   <= 1'b0;
          bus.datolec <= op ? bus.datolec : bus.ad_in;
        end else cnt <= cnt - CW'(1);
        GAP2: if (cnt == '0) begin
          state            <= DONE;
          bus.esclisto     <= op;
          bus.memorialisto <= ~op;
        end else cnt <= cnt - CW'(1);
        DONE: if (!(op ? bus.actesc : bus.actlec)) begin
          state            <= IDLE;
          bus.esclisto     <= 1'b0;
          bus.memorialisto <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
